// File: rtl/vid_delay_pkg.sv
// Shared constants and helpers for the vid_delay_line delay pipeline.
package vid_delay_pkg;

  localparam int unsigned DELAY_MAX_DEPTH = 64;

  // Width of a counter that must hold the values 0..depth inclusive.
  function automatic int unsigned fill_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/vid_delay_stage.sv
// One enabled register stage of the delay line; flush clears only the valid bit.
module vid_delay_stage #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  input  logic         flush,
  input  logic [W-1:0] d,
  input  logic         v,
  output logic [W-1:0] q,
  output logic         qv
);

  typedef struct packed {
    logic [W-1:0] data;
    logic         valid;
  } stage_t;

  stage_t r;

  // rst clears everything; flush drops valid but keeps data and blocks the shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      r.data  <= '0;
      r.valid <= 1'b0;
    end else if (flush) begin
      r.valid <= 1'b0;
    end else if (ce) begin
      r.data  <= d;
      r.valid <= v;
    end
  end

  assign q  = r.data;
  assign qv = r.valid;

endmodule

// File: rtl/vid_delay_line.sv
// Fixed-latency multi-channel delay line with valid tracking, flush and priming flag.
// Optional build macro VID_DELAY_LINE_ZERO_INVALID_EN zeroes data of invalid samples.
module vid_delay_line
  import vid_delay_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned CH    = 1,
  parameter int unsigned DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ce,
  input  logic            flush,
  input  logic [CH*N-1:0] idata,
  input  logic            ivalid,
  output logic [CH*N-1:0] odata,
  output logic            ovalid,
  output logic            primed
);

  localparam int unsigned W  = CH * N;
  localparam int unsigned FW = fill_w(DEPTH);

  if (DEPTH < 1 || DEPTH > DELAY_MAX_DEPTH) begin : g_depth_check
    $error("vid_delay_line: DEPTH must be within 1..64");
  end

  logic [W-1:0]  sd [DEPTH+1];
  logic          sv [DEPTH+1];
  logic [FW-1:0] cnt;

`ifdef VID_DELAY_LINE_ZERO_INVALID_EN
  assign sd[0] = ivalid ? idata : '0;
`else
  assign sd[0] = idata;
`endif
  assign sv[0] = ivalid;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    vid_delay_stage #(.W(W)) u_stage (
      .clk   (clk),
      .rst   (rst),
      .ce    (ce),
      .flush (flush),
      .d     (sd[k]),
      .v     (sv[k]),
      .q     (sd[k+1]),
      .qv    (sv[k+1])
    );
  end

  // Saturating count of enabled cycles since the last rst or flush.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      cnt <= '0;
    end else if (ce && (cnt != FW'(DEPTH))) begin
      cnt <= cnt + FW'(1);
    end
  end

  assign primed = (cnt == FW'(DEPTH));
  assign ovalid = sv[DEPTH];

`ifdef VID_DELAY_LINE_ZERO_INVALID_EN
  assign odata = sv[DEPTH] ? sd[DEPTH] : '0;
`else
  assign odata = sd[DEPTH];
`endif

endmodule

// File: tb/tb_vid_delay_line.sv
// Self-checking bench for vid_delay_line: DEPTH=3/CH=2 and DEPTH=1/N=12 instances.
module tb_vid_delay_line;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, ce_a, flush_a, ivalid_a, ovalid_a, primed_a;
  logic [15:0] idata_a, odata_a;
  logic        rst_b, ce_b, flush_b, ivalid_b, ovalid_b, primed_b;
  logic [11:0] idata_b, odata_b;

  int total = 0;
  int bad   = 0;

  logic [16:0] q_a [$];
  int          cnt_a;

  vid_delay_line #(.N(8), .CH(2), .DEPTH(3)) dut_a (
    .clk(clk), .rst(rst_a), .ce(ce_a), .flush(flush_a),
    .idata(idata_a), .ivalid(ivalid_a),
    .odata(odata_a), .ovalid(ovalid_a), .primed(primed_a)
  );

  vid_delay_line #(.N(12), .CH(1), .DEPTH(1)) dut_b (
    .clk(clk), .rst(rst_b), .ce(ce_b), .flush(flush_b),
    .idata(idata_b), .ivalid(ivalid_b),
    .odata(odata_b), .ovalid(ovalid_b), .primed(primed_b)
  );

  // Drive one cycle on instance A and update the in-flight sample queue.
  task automatic step_a(input logic r, input logic c, input logic f,
                        input logic [15:0] d, input logic v);
    logic [16:0] e;
    rst_a = r; ce_a = c; flush_a = f; idata_a = d; ivalid_a = v;
    @(posedge clk);
    if (r) begin
      q_a.delete();
      for (int i = 0; i < 3; i++) q_a.push_back(17'h0);
      cnt_a = 0;
    end else if (f) begin
      for (int i = 0; i < q_a.size(); i++) begin
        e = q_a[i]; e[0] = 1'b0; q_a[i] = e;
      end
      cnt_a = 0;
    end else if (c) begin
`ifdef VID_DELAY_LINE_ZERO_INVALID_EN
      q_a.push_back({(v ? d : 16'h0), v});
`else
      q_a.push_back({d, v});
`endif
      void'(q_a.pop_front());
      if (cnt_a < 3) cnt_a++;
    end
    #1;
  endtask

  function automatic logic exp_ov_a();
    logic [16:0] e;
    e = q_a[0];
    return e[0];
  endfunction

  function automatic logic [15:0] exp_od_a();
    logic [16:0] e;
    e = q_a[0];
`ifdef VID_DELAY_LINE_ZERO_INVALID_EN
    return e[0] ? e[16:1] : 16'h0;
`else
    return e[16:1];
`endif
  endfunction

  function automatic logic exp_pr_a();
    return cnt_a == 3;
  endfunction

  task automatic step_b(input logic r, input logic c, input logic [11:0] d, input logic v);
    rst_b = r; ce_b = c; flush_b = 1'b0; idata_b = d; ivalid_b = v;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step_a(1'b1, 1'b1, 1'b0, 16'hDEAD, 1'b1);
    total += 3;
    if (odata_a !== 16'h0) begin bad++; $display("FAIL reset odata got=%h want=0000", odata_a); end
    if (ovalid_a !== 1'b0) begin bad++; $display("FAIL reset ovalid got=%b want=0", ovalid_a); end
    if (primed_a !== 1'b0) begin bad++; $display("FAIL reset primed got=%b want=0", primed_a); end
  endtask

  task automatic test_fill();
    logic [15:0] d_t [6];
    d_t = '{16'h0102, 16'h0304, 16'h0506, 16'h0708, 16'h090A, 16'h0B0C};
    for (int i = 0; i < 6; i++) begin
      step_a(1'b0, 1'b1, 1'b0, d_t[i], 1'b1);
      total += 3;
      if (odata_a !== exp_od_a()) begin bad++; $display("FAIL fill odata step=%0d got=%h want=%h", i, odata_a, exp_od_a()); end
      if (ovalid_a !== exp_ov_a()) begin bad++; $display("FAIL fill ovalid step=%0d got=%b want=%b", i, ovalid_a, exp_ov_a()); end
      if (primed_a !== exp_pr_a()) begin bad++; $display("FAIL fill primed step=%0d got=%b want=%b", i, primed_a, exp_pr_a()); end
      if (i == 2) begin
        total++;
        if (odata_a !== 16'h0102 || ovalid_a !== 1'b1 || primed_a !== 1'b1) begin
          bad++; $display("FAIL fill third_edge got=%h/%b/%b want=0102/1/1", odata_a, ovalid_a, primed_a);
        end
      end
    end
  endtask

  task automatic test_ce_toggle();
    logic        c_t [5];
    logic [15:0] d_t [5];
    c_t = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    d_t = '{16'h00AA, 16'h00AA, 16'h00BB, 16'h00BB, 16'h00CC};
    step_a(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step_a(1'b0, c_t[i], 1'b0, d_t[i], 1'b1);
      total += 3;
      if (odata_a !== exp_od_a()) begin bad++; $display("FAIL ce_toggle odata step=%0d got=%h want=%h", i, odata_a, exp_od_a()); end
      if (ovalid_a !== exp_ov_a()) begin bad++; $display("FAIL ce_toggle ovalid step=%0d got=%b want=%b", i, ovalid_a, exp_ov_a()); end
      if (primed_a !== exp_pr_a()) begin bad++; $display("FAIL ce_toggle primed step=%0d got=%b want=%b", i, primed_a, exp_pr_a()); end
    end
    total++;
    if (odata_a !== 16'h00AA || ovalid_a !== 1'b1) begin
      bad++; $display("FAIL ce_toggle aa_out got=%h/%b want=00aa/1", odata_a, ovalid_a);
    end
  endtask

  task automatic test_valid_gap();
    logic [15:0] d_t [6];
    logic        v_t [6];
    logic [15:0] gap;
    d_t = '{16'h0011, 16'h0022, 16'h0033, 16'h0000, 16'h0000, 16'h0000};
    v_t = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
`ifdef VID_DELAY_LINE_ZERO_INVALID_EN
    gap = 16'h0000;
`else
    gap = 16'h0022;
`endif
    for (int i = 0; i < 6; i++) begin
      step_a(1'b0, 1'b1, 1'b0, d_t[i], v_t[i]);
      total += 2;
      if (odata_a !== exp_od_a()) begin bad++; $display("FAIL valid_gap odata step=%0d got=%h want=%h", i, odata_a, exp_od_a()); end
      if (ovalid_a !== exp_ov_a()) begin bad++; $display("FAIL valid_gap ovalid step=%0d got=%b want=%b", i, ovalid_a, exp_ov_a()); end
      if (i == 3) begin
        total++;
        if (odata_a !== gap || ovalid_a !== 1'b0) begin
          bad++; $display("FAIL valid_gap hole got=%h/%b want=%h/0", odata_a, ovalid_a, gap);
        end
      end
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) step_a(1'b0, 1'b1, 1'b0, 16'h0055, 1'b1);
    total++;
    if (ovalid_a !== 1'b1 || primed_a !== 1'b1) begin
      bad++; $display("FAIL flush full got=%b/%b want=1/1", ovalid_a, primed_a);
    end
    step_a(1'b0, 1'b1, 1'b1, 16'h0099, 1'b1);
    total += 3;
    if (ovalid_a !== 1'b0) begin bad++; $display("FAIL flush ovalid got=%b want=0", ovalid_a); end
    if (primed_a !== 1'b0) begin bad++; $display("FAIL flush primed got=%b want=0", primed_a); end
    if (odata_a !== exp_od_a()) begin bad++; $display("FAIL flush odata got=%h want=%h", odata_a, exp_od_a()); end
    for (int i = 0; i < 3; i++) begin
      step_a(1'b0, 1'b1, 1'b0, 16'h0077, 1'b1);
      total += 3;
      if (odata_a === 16'h0099) begin bad++; $display("FAIL flush dropped_sample got=%h want!=0099", odata_a); end
      if (primed_a !== exp_pr_a()) begin bad++; $display("FAIL flush reprime step=%0d got=%b want=%b", i, primed_a, exp_pr_a()); end
      if (ovalid_a !== exp_ov_a()) begin bad++; $display("FAIL flush ovalid_after step=%0d got=%b want=%b", i, ovalid_a, exp_ov_a()); end
    end
    total++;
    if (primed_a !== 1'b1 || odata_a !== 16'h0077) begin
      bad++; $display("FAIL flush reprimed got=%b/%h want=1/0077", primed_a, odata_a);
    end
  endtask

  task automatic test_rst_midstream();
    for (int i = 0; i < 2; i++) step_a(1'b0, 1'b1, 1'b0, 16'h1234, 1'b1);
    step_a(1'b1, 1'b0, 1'b0, 16'h5678, 1'b1);
    total += 3;
    if (odata_a !== 16'h0) begin bad++; $display("FAIL rst_mid odata got=%h want=0000", odata_a); end
    if (ovalid_a !== 1'b0) begin bad++; $display("FAIL rst_mid ovalid got=%b want=0", ovalid_a); end
    if (primed_a !== 1'b0) begin bad++; $display("FAIL rst_mid primed got=%b want=0", primed_a); end
    for (int i = 0; i < 3; i++) begin
      step_a(1'b0, 1'b1, 1'b0, 16'h4321, 1'b1);
      total++;
      if (primed_a !== (i == 2)) begin bad++; $display("FAIL rst_mid primed step=%0d got=%b want=%b", i, primed_a, (i == 2)); end
    end
  endtask

  task automatic test_back_to_back();
    logic c, f, v;
    logic [15:0] d;
    for (int i = 0; i < 60; i++) begin
      c = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 15) == 0);
      v = $urandom_range(0, 1) == 1;
      d = 16'($urandom);
      step_a(1'b0, c, f, d, v);
      total += 3;
      if (odata_a !== exp_od_a()) begin bad++; $display("FAIL b2b odata step=%0d got=%h want=%h", i, odata_a, exp_od_a()); end
      if (ovalid_a !== exp_ov_a()) begin bad++; $display("FAIL b2b ovalid step=%0d got=%b want=%b", i, ovalid_a, exp_ov_a()); end
      if (primed_a !== exp_pr_a()) begin bad++; $display("FAIL b2b primed step=%0d got=%b want=%b", i, primed_a, exp_pr_a()); end
    end
  endtask

  task automatic test_depth1();
    logic [11:0] zi;
    step_b(1'b1, 1'b1, 12'hABC, 1'b1);
    total++;
    if (odata_b !== 12'h0 || ovalid_b !== 1'b0 || primed_b !== 1'b0) begin
      bad++; $display("FAIL d1 reset got=%h/%b/%b want=000/0/0", odata_b, ovalid_b, primed_b);
    end
    step_b(1'b0, 1'b1, 12'hFFF, 1'b1);
    total += 3;
    if (odata_b !== 12'hFFF) begin bad++; $display("FAIL d1 odata got=%h want=fff", odata_b); end
    if (ovalid_b !== 1'b1) begin bad++; $display("FAIL d1 ovalid got=%b want=1", ovalid_b); end
    if (primed_b !== 1'b1) begin bad++; $display("FAIL d1 primed got=%b want=1", primed_b); end
    for (int i = 0; i < 10; i++) begin
      step_b(1'b0, 1'b1, 12'hFFF, 1'b1);
      total++;
      if (primed_b !== 1'b1) begin bad++; $display("FAIL d1 saturate step=%0d got=%b want=1", i, primed_b); end
    end
`ifdef VID_DELAY_LINE_ZERO_INVALID_EN
    zi = 12'h000;
`else
    zi = 12'h5A5;
`endif
    step_b(1'b0, 1'b1, 12'h5A5, 1'b0);
    total++;
    if (odata_b !== zi || ovalid_b !== 1'b0) begin
      bad++; $display("FAIL d1 invalid got=%h/%b want=%h/0", odata_b, ovalid_b, zi);
    end
    step_b(1'b0, 1'b0, 12'h123, 1'b1);
    total++;
    if (odata_b !== zi || ovalid_b !== 1'b0 || primed_b !== 1'b1) begin
      bad++; $display("FAIL d1 hold got=%h/%b/%b want=%h/0/1", odata_b, ovalid_b, primed_b, zi);
    end
  endtask

  initial begin
    rst_a = 1'b1; ce_a = 1'b0; flush_a = 1'b0; idata_a = '0; ivalid_a = 1'b0;
    rst_b = 1'b1; ce_b = 1'b0; flush_b = 1'b0; idata_b = '0; ivalid_b = 1'b0;
    @(negedge clk);
    test_reset();
    test_fill();
    test_ce_toggle();
    test_valid_gap();
    test_flush();
    test_rst_midstream();
    test_back_to_back();
    test_depth1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vid_delay_line.md
Name: vid_delay_line

Overview:
- Parametrised multi-stage, multi-channel delay line for the vision pipeline.
- Aligns pixel data and its valid flag with paths of known latency, e.g. window or line-buffer processing.
- Clock-enable-gated shift with valid tracking, flush, and a priming indicator.
- Sits between stream producers and combiners wherever side-band or pixel data must be delayed by a fixed number of enabled cycles.

Parameters:
- N, 8, bit width of one channel.
- CH, 1, number of channels carried in parallel (packed, channel 0 in LSBs).
- DEPTH, 2, number of register stages; legal range 1..64; elaboration-time assertion on violation.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- ce  input  1  clock enable; the shift advances only when high.
- flush  input  1  synchronous clear of valid state and priming counter.
- idata  input  CH*N  input sample, all channels.
- ivalid  input  1  input sample valid.
- odata  output  CH*N  sample delayed by DEPTH enabled cycles.
- ovalid  output  1  valid flag delayed by DEPTH enabled cycles.
- primed  output  1  high once DEPTH enabled cycles have elapsed since the last rst or flush.

Behaviour:
- Storage: DEPTH stages. Each stage holds CH*N data bits plus 1 valid bit.
- Shift on ce=1:
  - stage[0] <= {idata, ivalid}.
  - stage[k] <= stage[k-1] for k = 1..DEPTH-1.
- ce=0: all stages hold. The counter holds.
- Outputs:
  - odata/ovalid driven directly from stage[DEPTH-1], registered.
  - No combinational path from any input to any output.
- Latency: exactly DEPTH ce-high cycles. A sample applied on the edge of the k-th enabled cycle appears on the outputs after the (k+DEPTH-1)-th enabled edge.
- Priority, per edge: rst > flush > ce.
- rst:
  - all data bits = 0, all valid bits = 0, fill counter = 0.
  - Outputs after reset: odata=0, ovalid=0, primed=0.
  - Takes effect regardless of ce; aborts any in-flight samples.
- flush (rst=0):
  - all valid bits = 0, fill counter = 0.
  - Data bits are retained, not cleared.
  - If ce=1 in the same cycle, the shift is suppressed and the incoming sample is dropped.
- Fill counter:
  - Width $clog2(DEPTH+1).
  - Increments on each ce=1 cycle without rst/flush; saturates at DEPTH, no wrap.
  - primed = (counter == DEPTH), registered-equivalent (counter is a register, compare is combinational on it).
- ivalid=0 samples still shift through and occupy a stage. Gaps are preserved cycle-exact.
- DEPTH=1 degenerates to a single enabled register with valid; primed goes high after the first enabled cycle.

Optional Feature:
- Macro: VID_DELAY_LINE_ZERO_INVALID_EN.
- Defined:
  - stage[0] data loads 0 when ivalid=0.
  - odata is forced to 0 whenever ovalid=0, including after flush while stale data is retained.
- Undefined:
  - data shifts unmodified regardless of valid.
  - odata shows retained or stale content when ovalid=0.
- Port list is identical in both builds.

Decomposition:
- Package vid_delay_pkg:
  - localparam function for counter width, fill_w(depth) = $clog2(depth+1).
  - typedef for one stage record {data, valid} as a packed struct parametrised by width via the module.
  - Constant DELAY_MAX_DEPTH = 64.
- Sub-module vid_delay_stage:
  - one register stage with ce, rst, flush.
  - Data and valid handled separately so flush clears valid only.
  - Instantiated DEPTH times in a generate loop.
- Fill counter and primed logic live in the top module.

Test Plan:
- DEPTH=3, N=8, CH=2, ce=1 constant, idata=0x0102, 0x0304, 0x0506, each with ivalid=1 -> odata=0x0102 after the 3rd edge, ovalid=1, primed rises on the same edge.
- ce toggling 1,0,1,0,1 with idata=0xAA then 0xBB -> 0xAA appears only after the 3rd ce-high edge; outputs hold across ce=0 cycles.
- Valid gap: ivalid pattern 1,0,1 with data 0x11,0x22,0x33 -> ovalid pattern 1,0,1 exactly DEPTH enabled cycles later. odata=0x22 in the gap without the macro, 0x00 with it.
- flush together with ce=1 while pipe is full of valid 0x55 -> next edge ovalid=0 and primed=0. The sample presented in the flush cycle never emerges. primed re-asserts after 3 further ce cycles.
- rst asserted mid-stream with ce=0 -> next edge odata=0, ovalid=0, primed=0. After 2 enabled cycles with rst=0, primed is still 0 (DEPTH=3).
- DEPTH=1, N=12, CH=1: idata=0xFFF, ivalid=1, ce=1 -> odata=0xFFF, ovalid=1, primed=1 after one edge; counter saturates and does not wrap after 10 more ce cycles.
